// File: rtl/disk_ctrl_if.sv
// disk_ctrl_if
//   Bundles the signals around disk_ctrl: the CPU register bus (STB/WE/ADDR/
//   DAT_I/DAT_O/ACK), the byte-serial device handshake, the sector buffer
//   port, and the busy/irq status lines.
//   slave  : the disk_ctrl side (drives DAT_O, ACK, device/buffer outputs).
//   master : the environment side (CPU, device, sector buffer).
interface disk_ctrl_if;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    logic [7:0]  dev_data_in;
    logic        dev_read_done;
    logic        dev_writing;
    logic        dev_write_done;
    logic [7:0]  dev_data_out;
    logic        dev_we;

    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  buf_rdata;

    logic        busy;
    logic        irq;

    modport slave (
        input  STB, WE, ADDR, DAT_I,
        input  dev_data_in, dev_read_done, dev_writing, dev_write_done,
        input  buf_rdata,
        output DAT_O, ACK, dev_data_out, dev_we,
        output buf_addr, buf_wdata, buf_we, busy, irq
    );

    modport master (
        output STB, WE, ADDR, DAT_I,
        output dev_data_in, dev_read_done, dev_writing, dev_write_done,
        output buf_rdata,
        input  DAT_O, ACK, dev_data_out, dev_we,
        input  buf_addr, buf_wdata, buf_we, busy, irq
    );
endinterface

// File: rtl/disk_ctrl.sv
// disk_ctrl
//   Sector-transfer sequencer. A CMD write with bit31 set starts a transfer:
//   a 5-byte header (opcode, LBA MSB..LSB) goes to the device, then exactly
//   512 bytes move between device and sector buffer. Completion or watchdog
//   abort is reported in STATUS and by a one-cycle irq pulse.
//   Ports: clk, rst_n (async, active low), bus (disk_ctrl_if.slave).
//   Registers (ADDR[3:2]): 0 CMD (wo), 1 LBA (rw), 2 STATUS (r, W1C), 3 zero.
//
//   state      | meaning
//   S_IDLE     | waiting for a start command
//   S_HDR      | offering header byte hidx to the device
//   S_RD_DATA  | device -> buffer, one byte per dev_read_done
//   S_WR_FETCH | buffer address driven, read data arrives next cycle
//   S_WR_SEND  | offering fetched byte to the device
//   S_DONE     | one cycle: set done, pulse irq
//   S_ERR      | one cycle: set err+timeout, pulse irq
module disk_ctrl #(
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic [7:0]  OP_READ  = 8'h11,
    parameter logic [7:0]  OP_WRITE = 8'h22
) (
    input  logic        clk,
    input  logic        rst_n,
    disk_ctrl_if.slave  bus
);
    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RD_DATA, S_WR_FETCH, S_WR_SEND, S_DONE, S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [8:0]      cnt, cnt_nx;
    logic [2:0]      hidx, hidx_nx;
    logic [WD_W-1:0] wd, wd_nx;
    logic [7:0]      data_q, data_nx;
    logic            send_first, send_first_nx;

    logic [31:0] lba_reg, lba_q;
    logic        dir_q;
    logic        st_done, st_err, st_to, st_rej;

    logic        reg_wr, start_req, start, busy_w, wd_hit;
    logic [1:0]  reg_sel;
    logic [7:0]  hdr_byte;
    logic        unused_addr;

    assign reg_sel     = bus.ADDR[3:2];
    assign reg_wr      = bus.STB & bus.WE;
    assign start_req   = reg_wr && (reg_sel == 2'd0) && bus.DAT_I[31];
    assign start       = start_req && (state == S_IDLE);
    assign busy_w      = (state != S_IDLE);
    assign wd_hit      = (wd == WD_LAST);
    assign unused_addr = &{1'b0, bus.ADDR[31:4], bus.ADDR[1:0]};

    // register file and STATUS bits; sets from DONE/ERR override a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lba_reg <= '0;
            lba_q   <= '0;
            dir_q   <= 1'b0;
            st_done <= 1'b0;
            st_err  <= 1'b0;
            st_to   <= 1'b0;
            st_rej  <= 1'b0;
        end else begin
            if (reg_wr && reg_sel == 2'd1) lba_reg <= bus.DAT_I;
            if (reg_wr && reg_sel == 2'd2) begin
                if (bus.DAT_I[1]) st_done <= 1'b0;
                if (bus.DAT_I[2]) st_err  <= 1'b0;
                if (bus.DAT_I[3]) st_to   <= 1'b0;
                if (bus.DAT_I[4]) st_rej  <= 1'b0;
            end
            if (start_req) begin
                if (busy_w) begin
                    st_rej <= 1'b1;
                end else begin
                    dir_q   <= bus.DAT_I[0];
                    lba_q   <= lba_reg;
                    st_done <= 1'b0;
                    st_err  <= 1'b0;
                    st_to   <= 1'b0;
                end
            end
            if (state == S_DONE) st_done <= 1'b1;
            if (state == S_ERR) begin
                st_err <= 1'b1;
                st_to  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hidx       <= '0;
            wd         <= '0;
            data_q     <= '0;
            send_first <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            hidx       <= hidx_nx;
            wd         <= wd_nx;
            data_q     <= data_nx;
            send_first <= send_first_nx;
        end
    end

    // a handshake is checked before the watchdog so it always wins the tie
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        hidx_nx       = hidx;
        wd_nx         = wd;
        data_nx       = data_q;
        send_first_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_HDR;
                    cnt_nx   = '0;
                    hidx_nx  = '0;
                    wd_nx    = '0;
                end
            end
            S_HDR: begin
                if (bus.dev_write_done) begin
                    wd_nx = '0;
                    if (hidx == 3'd4) state_nx = dir_q ? S_WR_FETCH : S_RD_DATA;
                    else              hidx_nx  = hidx + 3'd1;
                end else if (wd_hit) begin
                    state_nx = S_ERR;
                end else begin
                    wd_nx = wd + WD_W'(1);
                end
            end
            S_RD_DATA: begin
                if (bus.dev_read_done) begin
                    wd_nx = '0;
                    if (cnt == 9'd511) state_nx = S_DONE;
                    else               cnt_nx   = cnt + 9'd1;
                end else if (wd_hit) begin
                    state_nx = S_ERR;
                end else begin
                    wd_nx = wd + WD_W'(1);
                end
            end
            S_WR_FETCH: begin
                state_nx      = S_WR_SEND;
                wd_nx         = '0;
                send_first_nx = 1'b1;
            end
            S_WR_SEND: begin
                if (send_first) data_nx = bus.buf_rdata;
                if (bus.dev_write_done) begin
                    wd_nx = '0;
                    if (cnt == 9'd511) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx   = cnt + 9'd1;
                        state_nx = S_WR_FETCH;
                    end
                end else if (wd_hit) begin
                    state_nx = S_ERR;
                end else begin
                    wd_nx = wd + WD_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        hdr_byte = lba_q[7:0];
        case (hidx)
            3'd0:    hdr_byte = dir_q ? OP_WRITE : OP_READ;
            3'd1:    hdr_byte = lba_q[31:24];
            3'd2:    hdr_byte = lba_q[23:16];
            3'd3:    hdr_byte = lba_q[15:8];
            default: hdr_byte = lba_q[7:0];
        endcase
    end

    // buffer data is only valid in the first WR_SEND cycle, so it is passed
    // straight through then and held from data_q afterwards
    always_comb begin
        bus.dev_we       = 1'b0;
        bus.dev_data_out = '0;
        bus.buf_addr     = '0;
        bus.buf_we       = 1'b0;
        case (state)
            S_HDR: begin
                bus.dev_we       = ~bus.dev_writing;
                bus.dev_data_out = hdr_byte;
            end
            S_RD_DATA: begin
                bus.buf_addr = cnt;
                bus.buf_we   = bus.dev_read_done;
            end
            S_WR_FETCH: bus.buf_addr = cnt;
            S_WR_SEND: begin
                bus.buf_addr     = cnt;
                bus.dev_we       = ~bus.dev_writing;
                bus.dev_data_out = send_first ? bus.buf_rdata : data_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.DAT_O = '0;
        if (bus.STB) begin
            case (reg_sel)
                2'd1:    bus.DAT_O = lba_reg;
                2'd2:    bus.DAT_O = {27'd0, st_rej, st_to, st_err, st_done, busy_w};
                default: bus.DAT_O = '0;
            endcase
        end
    end

    assign bus.ACK       = bus.STB;
    assign bus.buf_wdata = bus.dev_data_in;
    assign bus.busy      = busy_w;
    assign bus.irq       = (state == S_DONE) || (state == S_ERR);
endmodule

// File: tb/tb_disk_ctrl.sv
`timescale 1ns/1ps
module tb_disk_ctrl;
    localparam int unsigned TMO = 100;
    localparam logic [31:0] A_CMD = 32'h0, A_LBA = 32'h4, A_STAT = 32'h8, A_R3 = 32'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    disk_ctrl_if bus();
    disk_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int errors   = 0;
    int hs_fail  = 0;
    int stab_err = 0;
    int rdw_err  = 0;
    int irq_cnt  = 0;

    logic       do_preload = 1'b0;
    logic [7:0] mem      [512];
    logic [7:0] init_mem [512];
    logic [7:0] exp_buf  [512];
    logic [7:0] got      [512];

    // sector buffer: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_mem[i];
        end else if (bus.buf_we) begin
            mem[bus.buf_addr] <= bus.buf_wdata;
        end
        bus.buf_rdata <= mem[bus.buf_addr];
    end

    always @(posedge clk) if (bus.irq === 1'b1) irq_cnt++;

    function automatic logic [7:0] hdr_ref(input bit dir, input logic [31:0] lba, input int i);
        if (i == 0) return dir ? 8'h22 : 8'h11;
        return 8'((lba >> (8 * (4 - i))) & 32'hFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = a; bus.DAT_I = d;
        @(negedge clk);
        bus.STB = 1'b0; bus.WE = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.STB = 1'b1; bus.WE = 1'b0; bus.ADDR = a;
        #1 d = bus.DAT_O;
        @(negedge clk);
        bus.STB = 1'b0;
    endtask

    // device accepting one byte: waits for dev_we, holds dev_writing for
    // 'stall' cycles, then pulses dev_write_done
    task automatic dev_accept(input int stall, output logic [7:0] b);
        int n = 0;
        b = 8'h00;
        if (hs_fail > 0) return;
        while (bus.dev_we !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.dev_we !== 1'b1) begin
            hs_fail++;
            return;
        end
        b = bus.dev_data_out;
        if (stall > 0) begin
            bus.dev_writing = 1'b1;
            #1 if (bus.dev_we !== 1'b0) stab_err++;
            repeat (stall) @(negedge clk);
            bus.dev_writing = 1'b0;
        end
        #1 if (bus.dev_we !== 1'b1 || bus.dev_data_out !== b) stab_err++;
        bus.dev_write_done = 1'b1;
        @(negedge clk);
        bus.dev_write_done = 1'b0;
    endtask

    task automatic dev_send(input logic [7:0] b, input int idx, input int gap);
        repeat (gap) @(negedge clk);
        bus.dev_data_in = b;
        bus.dev_read_done = 1'b1;
        #1 if (bus.buf_we !== 1'b1 || bus.buf_addr !== 9'(idx)) rdw_err++;
        @(negedge clk);
        bus.dev_read_done = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] lba, input bit dir, input string tag);
        bus_write(A_LBA, lba);
        bus_write(A_CMD, {1'b1, 30'd0, dir});
        chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_dev_we_start"}, {31'd0, bus.dev_we}, 32'd1);
    endtask

    task automatic do_header(input bit dir, input logic [31:0] lba, input string tag);
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            dev_accept(int'($urandom_range(0, 3)), b);
            chk($sformatf("%s_hdr%0d", tag, i), {24'd0, b}, {24'd0, hdr_ref(dir, lba, i)});
        end
    endtask

    task automatic feed_read(input int n, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            exp_buf[i] = d;
            dev_send(d, i, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic read_sector(input logic [31:0] lba, input bit rnd, input string tag);
        int irq0, nmis;
        logic [31:0] rd;
        irq0 = irq_cnt;
        start_cmd(lba, 1'b0, tag);
        do_header(1'b0, lba, tag);
        feed_read(512, rnd);
        chk({tag, "_irq_after_last"}, {31'd0, bus.irq}, 32'd1);
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        nmis = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== exp_buf[i]) nmis++;
        chk({tag, "_buffer_mismatches"}, nmis, 0);
        chk({tag, "_buf_we_addr_errs"}, rdw_err, 0);
        chk({tag, "_handshake_timeouts"}, hs_fail, 0);
        bus_read(A_STAT, rd);
        chk({tag, "_status"}, rd, 32'h2);
        chk({tag, "_irq_count"}, irq_cnt - irq0, 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] lba;
        logic [7:0]  b;
        int irq0, nmis, k;

        bus.STB = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.DAT_I = '0;
        bus.dev_data_in = '0; bus.dev_read_done = 1'b0;
        bus.dev_writing = 1'b0; bus.dev_write_done = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_dev_we", {31'd0, bus.dev_we}, 32'd0);
        chk("rst_buf_we", {31'd0, bus.buf_we}, 32'd0);
        chk("rst_dev_data_out", {24'd0, bus.dev_data_out}, 32'd0);
        chk("rst_buf_addr", {23'd0, bus.buf_addr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, rd); chk("rst_status", rd, 32'h0);
        bus_read(A_LBA, rd);  chk("rst_lba", rd, 32'h0);

        // register map, ACK, idle-state handshake filtering
        bus_write(A_LBA, 32'hA5C3_0F96);
        bus_read(A_LBA, rd);  chk("lba_readback", rd, 32'hA5C3_0F96);
        bus_read(A_CMD, rd);  chk("cmd_reads_zero", rd, 32'h0);
        bus_read(A_R3, rd);   chk("reg3_reads_zero", rd, 32'h0);
        #1 chk("dat_o_unselected", bus.DAT_O, 32'h0);
        bus.STB = 1'b1; bus.WE = 1'b0; bus.ADDR = A_R3;
        #1 chk("ack_follows_stb", {31'd0, bus.ACK}, 32'd1);
        @(negedge clk); bus.STB = 1'b0;
        bus.dev_read_done = 1'b1;
        #1 chk("idle_read_done_ignored", {31'd0, bus.buf_we}, 32'd0);
        bus.dev_write_done = 1'b1;
        @(negedge clk);
        bus.dev_read_done = 1'b0; bus.dev_write_done = 1'b0;
        chk("idle_write_done_ignored", {31'd0, bus.busy}, 32'd0);

        // read sector, incrementing data pattern
        read_sector(32'h0000_1234, 1'b0, "rd1");

        // write sector with ~i preload, 3-cycle device stall, rejected restart
        for (int i = 0; i < 512; i++) init_mem[i] = ~8'(i);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
        lba = $urandom;
        irq0 = irq_cnt;
        stab_err = 0;
        start_cmd(lba, 1'b1, "wr");
        do_header(1'b1, lba, "wr");
        for (int i = 0; i < 512; i++) begin
            if (i == 100) begin
                bus_write(A_CMD, 32'h8000_0000);
                bus_read(A_STAT, rd);
                chk("wr_status_rej_busy", rd, 32'h11);
            end
            dev_accept(3, got[i]);
        end
        chk("wr_irq_after_last", {31'd0, bus.irq}, 32'd1);
        @(negedge clk);
        chk("wr_no_extra_offer", {31'd0, bus.dev_we}, 32'd0);
        chk("wr_busy_end", {31'd0, bus.busy}, 32'd0);
        nmis = 0;
        for (int i = 0; i < 512; i++) if (got[i] !== init_mem[i]) nmis++;
        chk("wr_byte_mismatches", nmis, 0);
        chk("wr_data_stability_errs", stab_err, 0);
        chk("wr_handshake_timeouts", hs_fail, 0);
        chk("wr_irq_count", irq_cnt - irq0, 1);
        bus_read(A_STAT, rd); chk("wr_status", rd, 32'h12);
        bus_write(A_STAT, 32'h1E);
        bus_read(A_STAT, rd); chk("w1c_clears", rd, 32'h0);

        // watchdog: device stops after 10 bytes
        irq0 = irq_cnt;
        lba = $urandom;
        start_cmd(lba, 1'b0, "tmo");
        do_header(1'b0, lba, "tmo");
        feed_read(10, 1'b1);
        k = 1;
        while (k <= 300) begin
            @(negedge clk);
            if (bus.irq === 1'b1) break;
            k++;
        end
        chk("tmo_cycles_to_irq", k, TMO);
        @(negedge clk);
        chk("tmo_busy_dropped", {31'd0, bus.busy}, 32'd0);
        bus_read(A_STAT, rd); chk("tmo_status", rd, 32'hC);
        chk("tmo_irq_count", irq_cnt - irq0, 1);
        bus_write(A_STAT, 32'h1E);

        // async reset at byte 200 of a read
        lba = $urandom;
        start_cmd(lba, 1'b0, "rst");
        do_header(1'b0, lba, "rst");
        feed_read(200, 1'b1);
        irq0 = irq_cnt;
        bus.dev_data_in = 8'h5A;
        bus.dev_read_done = 1'b1;
        #1 chk("rst_pre_buf_we", {31'd0, bus.buf_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_async_dev_we", {31'd0, bus.dev_we}, 32'd0);
        chk("rst_async_buf_we", {31'd0, bus.buf_we}, 32'd0);
        chk("rst_async_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        bus.dev_read_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_irq", irq_cnt - irq0, 0);
        bus_read(A_STAT, rd); chk("rst_status_cleared", rd, 32'h0);
        bus_read(A_LBA, rd);  chk("rst_lba_cleared", rd, 32'h0);

        // fresh transfer after reset, random LBA and data
        read_sector($urandom, 1'b1, "rd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
